seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture.sv | 102 ++++++++++
 tb/tb_seg7_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// seg7_capture: samples a scanned 4-digit 7-segment display, debounces each digit,
// decodes it to a hex nibble and hands out complete frames with a valid/ready handshake.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [6:0]  Seg_n,
    input  logic [3:0]  Dig_n,
    output logic [15:0] Frame,
    output logic [3:0]  Err,
    output logic        Valid,
    input  logic        Ready,
    output logic        Overrun
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    localparam logic [7:0] N = 8'(STABLE_CYCLES);

    state_t      state;
    logic [6:0]  seg_q, seg_p;
    logic [3:0]  dig_q, dig_p;
    logic [7:0]  cnt;
    logic [3:0]  capd;
    logic [15:0] wbuf;
    logic [3:0]  werr;
    logic [3:0]  sel;
    logic [1:0]  idx;
    logic [4:0]  dnib;
    logic [7:0]  nxt_cnt;
    logic        legal, changed, run, cap, copy;

    function automatic logic [4:0] dec(input logic [6:0] s);
        case (s)
            7'h40: dec = 5'h00;
            7'h79: dec = 5'h01;
            7'h24: dec = 5'h02;
            7'h30: dec = 5'h03;
            7'h19: dec = 5'h04;
            7'h12: dec = 5'h05;
            7'h02: dec = 5'h06;
            7'h78: dec = 5'h07;
            7'h00: dec = 5'h08;
            7'h10: dec = 5'h09;
            7'h08: dec = 5'h0A;
            7'h03: dec = 5'h0B;
            7'h46: dec = 5'h0C;
            7'h21: dec = 5'h0D;
            7'h06: dec = 5'h0E;
            7'h0E: dec = 5'h0F;
            default: dec = 5'h10;
        endcase
    endfunction

    // run: a counting cycle (fresh start or continued settle); HOLD without change never recounts
    always_comb begin
        sel     = ~dig_q;
        legal   = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
        changed = (seg_q != seg_p) || (dig_q != dig_p);
        idx     = sel[3] ? 2'd3 : sel[2] ? 2'd2 : sel[1] ? 2'd1 : 2'd0;
        dnib    = dec(seg_q);
        nxt_cnt = (state == SETTLE && !changed) ? cnt + 8'd1 : 8'd1;
        run     = legal && !(state == HOLD && !changed);
        cap     = run && (nxt_cnt == N);
        copy    = &capd;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            seg_q   <= 7'h7F;
            seg_p   <= 7'h7F;
            dig_q   <= 4'hF;
            dig_p   <= 4'hF;
            state   <= IDLE;
            cnt     <= 8'd0;
            capd    <= 4'd0;
            wbuf    <= 16'h0000;
            werr    <= 4'h0;
            Frame   <= 16'h0000;
            Err     <= 4'h0;
            Valid   <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            seg_q <= Seg_n;
            dig_q <= Dig_n;
            seg_p <= seg_q;
            dig_p <= dig_q;
            state <= !legal ? IDLE : cap ? HOLD : run ? SETTLE : state;
            cnt   <= !legal ? 8'd0 : run ? nxt_cnt : cnt;
            if (cap) begin
                wbuf[{idx, 2'b00} +: 4] <= dnib[3:0];
                werr[idx]               <= dnib[4];
            end
            capd <= (copy ? 4'd0 : capd) | (cap ? 4'(4'd1 << idx) : 4'd0);
            if (copy) begin
                Frame <= wbuf;
                Err   <= werr;
            end
            Valid   <= copy || (Valid && !Ready);
            Overrun <= (copy && Valid && !Ready) ? 1'b1 : (Valid && Ready) ? 1'b0 : Overrun;
        end
    end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: vector table of display frames plus hand-written debounce, handshake and reset sequences.
module tb_seg7_capture;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Ready = 1'b0;
    logic [6:0]  Seg_n = 7'h7F;
    logic [3:0]  Dig_n = 4'hF;
    logic [15:0] Frame;
    logic [3:0]  Err;
    logic        Valid;
    logic        Overrun;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] frame;
        logic [3:0]  err;
    } exp_t;
    typedef struct {
        logic [6:0]  seg [4];
        logic [15:0] frame;
        logic [3:0]  err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs [6];

    always #5 Clk = ~Clk;

    seg7_capture #(.STABLE_CYCLES(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Seg_n(Seg_n), .Dig_n(Dig_n),
        .Frame(Frame), .Err(Err), .Valid(Valid), .Ready(Ready), .Overrun(Overrun)
    );

    function automatic vec_t mk(input logic [6:0] a, b, c, d, input logic [15:0] f, input logic [3:0] e);
        vec_t v;
        v.seg[0] = a;
        v.seg[1] = b;
        v.seg[2] = c;
        v.seg[3] = d;
        v.frame  = f;
        v.err    = e;
        return v;
    endfunction

    function automatic logic [3:0] dig_of(input int k);
        return ~(4'd1 << k);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
        Dig_n = d;
        Seg_n = s;
        repeat (n) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        sb.push_back({v.frame, v.err});
        for (int k = 0; k < 4; k++) hold(dig_of(k), v.seg[k], 6);
    endtask

    task automatic expect_frame(input string name);
        exp_t e;
        int b = 0;
        while (!Valid && b < 20) begin
            tick();
            b++;
        end
        chk({name, " valid"}, 32'(Valid), 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk({name, " frame"}, 32'(Frame), 32'(e.frame));
        chk({name, " err"}, 32'(Err), 32'(e.err));
    endtask

    task automatic accept();
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t junk;
        vecs[0] = mk(7'h79, 7'h24, 7'h30, 7'h19, 16'h4321, 4'h0);
        vecs[1] = mk(7'h40, 7'h12, 7'h02, 7'h78, 16'h7650, 4'h0);
        vecs[2] = mk(7'h00, 7'h10, 7'h08, 7'h03, 16'hBA98, 4'h0);
        vecs[3] = mk(7'h46, 7'h21, 7'h06, 7'h0E, 16'hFEDC, 4'h0);
        vecs[4] = mk(7'h79, 7'h24, 7'h7F, 7'h19, 16'h4021, 4'b0100);
        vecs[5] = mk(7'h7F, 7'h00, 7'h55, 7'h40, 16'h0080, 4'b0101);
        #1 Reset_n = 1'b0;
        repeat (3) tick();
        chk("reset frame", 32'(Frame), 32'h0);
        chk("reset err", 32'(Err), 32'h0);
        chk("reset valid", 32'(Valid), 32'h0);
        chk("reset overrun", 32'(Overrun), 32'h0);
        Reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i]);
            expect_frame($sformatf("vec%0d", i));
            chk($sformatf("vec%0d overrun", i), 32'(Overrun), 32'h0);
            accept();
            chk($sformatf("vec%0d accepted", i), 32'(Valid), 32'h0);
        end
        // a 3-cycle hold is not captured, so the frame stays incomplete
        hold(4'hE, 7'h79, 6);
        hold(4'hD, 7'h40, 3);
        hold(4'hB, 7'h30, 6);
        hold(4'h7, 7'h19, 6);
        chk("short hold no frame", 32'(Valid), 32'h0);
        hold(4'hD, 7'h24, 4);
        hold(4'hB, 7'h30, 2);
        sb.push_back({16'h4321, 4'h0});
        expect_frame("four cycle hold");
        accept();
        // illegal selects mid-settle abort the count and it restarts at 1
        hold(4'hE, 7'h79, 3);
        hold(4'hC, 7'h79, 2);
        hold(4'hE, 7'h79, 3);
        hold(4'hF, 7'h79, 2);
        hold(4'hD, 7'h24, 6);
        hold(4'hB, 7'h30, 6);
        hold(4'h7, 7'h19, 6);
        chk("abort no frame", 32'(Valid), 32'h0);
        hold(4'hE, 7'h06, 4);
        hold(4'hF, 7'h7F, 2);
        sb.push_back({16'h432E, 4'h0});
        expect_frame("restart");
        accept();
        // two frames without Ready: second overwrites, Overrun sets
        send(vecs[0]);
        chk("first pending valid", 32'(Valid), 32'h1);
        chk("first pending overrun", 32'(Overrun), 32'h0);
        send(vecs[1]);
        chk("overrun set", 32'(Overrun), 32'h1);
        junk = sb.pop_front();
        expect_frame("overwritten");
        accept();
        chk("overrun accept valid", 32'(Valid), 32'h0);
        chk("overrun cleared", 32'(Overrun), 32'h0);
        // copy and acceptance on the same edge
        send(vecs[2]);
        expect_frame("pending before same edge");
        for (int k = 0; k < 3; k++) hold(dig_of(k), vecs[3].seg[k], 6);
        hold(dig_of(3), vecs[3].seg[3], 5);
        sb.push_back({vecs[3].frame, vecs[3].err});
        accept();
        chk("same edge valid", 32'(Valid), 32'h1);
        chk("same edge overrun", 32'(Overrun), 32'h0);
        expect_frame("same edge");
        accept();
        chk("same edge drained", 32'(Valid), 32'h0);
        // asynchronous reset with a pending, overrun frame
        send(vecs[0]);
        send(vecs[1]);
        hold(4'hE, 7'h79, 3);
        #2 Reset_n = 1'b0;
        #1;
        chk("async reset frame", 32'(Frame), 32'h0);
        chk("async reset err", 32'(Err), 32'h0);
        chk("async reset valid", 32'(Valid), 32'h0);
        chk("async reset overrun", 32'(Overrun), 32'h0);
        sb.delete();
        tick();
        tick();
        Reset_n = 1'b1;
        hold(4'hE, 7'h79, 2);
        chk("post reset idle", 32'(Valid), 32'h0);
        send(vecs[1]);
        expect_frame("post reset");
        accept();
        chk("post reset drained", 32'(Valid), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
